// File: rtl/button_repeat_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
//   Shared definitions for the push-button command front end of the Tetris
//   game logic: channel FSM state encodings, button index constants and the
//   number of buttons.
//   Optional feature macro used by the importing files: AUTO_REPEAT_EN.
// -----------------------------------------------------------------------------
package button_pkg;

   localparam int unsigned NUM_BTN = 5;

   // Bit positions of each button in o_lvl and REPEAT_MASK.
   localparam int unsigned BTN_C = 0;
   localparam int unsigned BTN_E = 1;
   localparam int unsigned BTN_W = 2;
   localparam int unsigned BTN_S = 3;
   localparam int unsigned BTN_N = 4;

   // Per-channel state. HOLD_DLY/HOLD_RPT are only reachable when
   // AUTO_REPEAT_EN is defined.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HELD     = 2'd1,
      HOLD_DLY = 2'd2,
      HOLD_RPT = 2'd3
   } ch_state_t;

endpackage

// File: rtl/button_repeat_ctrl_if.sv
// -----------------------------------------------------------------------------
// button_repeat_ctrl_if
//   Bundle between a button source and a button channel.
//   raw     : raw asynchronous button level(s), 1 = pressed
//   pls     : registered single-cycle command pulse(s)
//   pls_nxt : value pls takes on the next edge (lets the consumer build
//             registered aggregates aligned with pls)
//   lvl     : debounced level(s)
//   modport master : the channel side (drives pls/pls_nxt/lvl)
//   modport slave  : the source/consumer side (drives raw)
// -----------------------------------------------------------------------------
interface button_repeat_ctrl_if #(
   parameter int unsigned W = 1
);
   logic [W-1:0] raw;
   logic [W-1:0] pls;
   logic [W-1:0] pls_nxt;
   logic [W-1:0] lvl;

   modport master (input raw, output pls, output pls_nxt, output lvl);
   modport slave  (output raw, input pls, input pls_nxt, input lvl);
endinterface

// File: rtl/button_repeat_ctrl_channel.sv
// -----------------------------------------------------------------------------
// button_channel
//   One push-button: two-flop synchroniser, debounce filter, press pulse and
//   optional hold-to-repeat.
//   Macro AUTO_REPEAT_EN: when defined, the HOLD_DLY/HOLD_RPT states and the
//   repeat counter are built and REPEAT_EN selects them after a press; when
//   undefined every press goes IDLE->HELD (one pulse per press).
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset
//     bus  : master modport (raw in; pls, pls_nxt, lvl out)
// -----------------------------------------------------------------------------
module button_channel
   import button_pkg::*;
#(
   parameter int unsigned CW         = 24,
   parameter int unsigned DEB_CYC    = 250000
`ifdef AUTO_REPEAT_EN
   ,
   parameter int unsigned DELAY_CYC  = 6250000,
   parameter int unsigned REPEAT_CYC = 1250000,
   parameter bit          REPEAT_EN  = 1'b0
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   button_repeat_ctrl_if.master bus
);

   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_lvl;
   logic          r_pls;
   logic [CW-1:0] r_deb_cnt;
   ch_state_t     r_state;

   logic w_mismatch;
   logic w_accept;
   logic w_press;
   logic w_release;
   logic w_pls_nxt;

   assign w_mismatch = (r_sync2 != r_lvl);
   assign w_accept   = w_mismatch && (r_deb_cnt == DEB_LAST);
   assign w_press    = w_accept && !r_lvl;
   assign w_release  = w_accept &&  r_lvl;

`ifdef AUTO_REPEAT_EN
   localparam logic [CW-1:0] DLY_LAST = CW'(DELAY_CYC - 1);
   localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYC - 1);
   logic [CW-1:0] r_rpt_cnt;
`endif

   // Pulse decision shared by the channel register and the top-level
   // registered OR, so both see the pulse on the same edge.
   // An accepted release always wins over a coincident repeat pulse.
   always_comb begin
      w_pls_nxt = 1'b0;
      case (r_state)
         IDLE: w_pls_nxt = w_press;
`ifdef AUTO_REPEAT_EN
         // The initial delay only advances while the synchronised input is
         // still pressed, so a release seen during the delay can never
         // produce a repeat even before the debounce accepts it.
         HOLD_DLY: w_pls_nxt = !w_release && r_sync2 && (r_rpt_cnt == DLY_LAST);
         // Once repeating, the button counts as held until the release is
         // accepted; short drop-outs do not interrupt the cadence.
         HOLD_RPT: w_pls_nxt = !w_release && (r_rpt_cnt == RPT_LAST);
`endif
         default: w_pls_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_lvl     <= 1'b0;
         r_pls     <= 1'b0;
         r_deb_cnt <= '0;
         r_state   <= IDLE;
`ifdef AUTO_REPEAT_EN
         r_rpt_cnt <= '0;
`endif
      end else begin
         r_sync1 <= bus.raw;
         r_sync2 <= r_sync1;
         r_pls   <= w_pls_nxt;

         if (!w_mismatch || w_accept) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt != DEB_LAST) begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
         end

         if (w_accept) begin
            r_lvl <= r_sync2;
         end

         case (r_state)
            IDLE: begin
               if (w_press) begin
`ifdef AUTO_REPEAT_EN
                  r_rpt_cnt <= '0;
                  r_state   <= REPEAT_EN ? HOLD_DLY : HELD;
`else
                  r_state   <= HELD;
`endif
               end
            end
            HELD: begin
               if (w_release) begin
                  r_state <= IDLE;
               end
            end
`ifdef AUTO_REPEAT_EN
            HOLD_DLY: begin
               if (w_release) begin
                  r_rpt_cnt <= '0;
                  r_state   <= IDLE;
               end else if (r_sync2) begin
                  if (r_rpt_cnt == DLY_LAST) begin
                     r_rpt_cnt <= '0;
                     r_state   <= HOLD_RPT;
                  end else begin
                     r_rpt_cnt <= r_rpt_cnt + 1'b1;
                  end
               end
            end
            HOLD_RPT: begin
               if (w_release) begin
                  r_rpt_cnt <= '0;
                  r_state   <= IDLE;
               end else if (r_rpt_cnt == RPT_LAST) begin
                  r_rpt_cnt <= '0;
               end else begin
                  r_rpt_cnt <= r_rpt_cnt + 1'b1;
               end
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.pls     = r_pls;
   assign bus.pls_nxt = w_pls_nxt;
   assign bus.lvl     = r_lvl;

endmodule

// File: rtl/button_repeat_ctrl.sv
// -----------------------------------------------------------------------------
// button_repeat_ctrl
//   Turns the five raw board buttons (C/E/W/S/N) into clean single-cycle
//   command pulses for the Tetris game logic.
//   Macro AUTO_REPEAT_EN: when defined, buttons selected by REPEAT_MASK
//   auto-repeat while held; when undefined REPEAT_MASK is ignored and each
//   accepted press gives exactly one pulse.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     i_button_c/e/w/s/n  : raw asynchronous buttons, 1 = pressed
//     o_pls_c/e/w/s/n     : single-cycle command pulses
//     o_lvl[4:0]          : debounced levels, bit0=C .. bit4=N
//     o_any_pls           : registered OR of the five pulses
// -----------------------------------------------------------------------------
module button_repeat_ctrl
   import button_pkg::*;
#(
   parameter int unsigned        CW          = 24,
   parameter int unsigned        DEB_CYC     = 250000,
   parameter int unsigned        DELAY_CYC   = 6250000,
   parameter int unsigned        REPEAT_CYC  = 1250000,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK = 5'b00110
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_button_c,
   input  logic               i_button_e,
   input  logic               i_button_w,
   input  logic               i_button_s,
   input  logic               i_button_n,
   output logic               o_pls_c,
   output logic               o_pls_e,
   output logic               o_pls_w,
   output logic               o_pls_s,
   output logic               o_pls_n,
   output logic [NUM_BTN-1:0] o_lvl,
   output logic               o_any_pls
);

   logic [NUM_BTN-1:0] w_raw;
   logic [NUM_BTN-1:0] w_pls;
   logic [NUM_BTN-1:0] w_pls_nxt;
   logic               r_any_pls;

   assign w_raw[BTN_C] = i_button_c;
   assign w_raw[BTN_E] = i_button_e;
   assign w_raw[BTN_W] = i_button_w;
   assign w_raw[BTN_S] = i_button_s;
   assign w_raw[BTN_N] = i_button_n;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      button_repeat_ctrl_if #(.W(1)) u_if ();

      assign u_if.raw     = w_raw[g];
      assign w_pls[g]     = u_if.pls;
      assign w_pls_nxt[g] = u_if.pls_nxt;
      assign o_lvl[g]     = u_if.lvl;

      button_channel #(
         .CW         (CW),
         .DEB_CYC    (DEB_CYC)
`ifdef AUTO_REPEAT_EN
         ,
         .DELAY_CYC  (DELAY_CYC),
         .REPEAT_CYC (REPEAT_CYC),
         .REPEAT_EN  (REPEAT_MASK[g])
`endif
      ) u_ch (
         .clk (clk),
         .rst (rst),
         .bus (u_if.master)
      );
   end

   // Registered from the channels' next-pulse values so it lands on the
   // same edge as the individual pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_any_pls <= 1'b0;
      end else begin
         r_any_pls <= |w_pls_nxt;
      end
   end

   assign o_pls_c   = w_pls[BTN_C];
   assign o_pls_e   = w_pls[BTN_E];
   assign o_pls_w   = w_pls[BTN_W];
   assign o_pls_s   = w_pls[BTN_S];
   assign o_pls_n   = w_pls[BTN_N];
   assign o_any_pls = r_any_pls;

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_repeat_ctrl
//   Scoreboard bench for button_repeat_ctrl with DEB_CYC=4, DELAY_CYC=10,
//   REPEAT_CYC=3, REPEAT_MASK=5'b00110. Repeat expectations depend on
//   AUTO_REPEAT_EN. Every output event (any pulse or any o_lvl change) is
//   matched against a queue of hand-computed expected events; cycle numbers
//   are counted from the edge at which the scenario's stimulus is applied.
// -----------------------------------------------------------------------------
module tb_button_repeat_ctrl;
   import button_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   button_repeat_ctrl_if #(.W(NUM_BTN)) bus ();

   logic               o_pls_c, o_pls_e, o_pls_w, o_pls_s, o_pls_n;
   logic [NUM_BTN-1:0] o_lvl;
   logic               o_any_pls;

   button_repeat_ctrl #(
      .CW          (8),
      .DEB_CYC     (4),
      .DELAY_CYC   (10),
      .REPEAT_CYC  (3),
      .REPEAT_MASK (5'b00110)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_button_c (bus.raw[0]),
      .i_button_e (bus.raw[1]),
      .i_button_w (bus.raw[2]),
      .i_button_s (bus.raw[3]),
      .i_button_n (bus.raw[4]),
      .o_pls_c    (o_pls_c),
      .o_pls_e    (o_pls_e),
      .o_pls_w    (o_pls_w),
      .o_pls_s    (o_pls_s),
      .o_pls_n    (o_pls_n),
      .o_lvl      (o_lvl),
      .o_any_pls  (o_any_pls)
   );

   assign bus.pls     = {o_pls_n, o_pls_s, o_pls_w, o_pls_e, o_pls_c};
   assign bus.lvl     = o_lvl;
   assign bus.pls_nxt = '0;

   always #5 clk = ~clk;

   typedef struct {
      int           cyc;
      logic [4:0]   pls;
      logic [4:0]   lvl;
   } ev_t;

   ev_t  exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc_cnt  = 0;
   int   base     = 0;
   logic mon_en   = 1'b0;
   logic [4:0] prev_lvl = '0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt - base);
      end
   endtask

   task automatic push(input int c, input logic [4:0] p, input logic [4:0] l);
      ev_t e;
      e.cyc = c;
      e.pls = p;
      e.lvl = l;
      exp_q.push_back(e);
   endtask

   // Apply button vector b at cycle 0, drop it after cycle hold-1, pulse rst
   // for one cycle at rst_at (negative = never), run total cycles.
   task automatic run(input logic [4:0] b, input int hold, input int rst_at, input int total);
      @(posedge clk); #1;
      base    = cyc_cnt;
      bus.raw = b;
      for (int k = 1; k <= total; k++) begin
         @(posedge clk); #1;
         if (k == hold) bus.raw = '0;
         rst = (k == rst_at);
      end
      chk("missing_events", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Monitor: any pulse or level change is an output event.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && (bus.pls != 5'b0 || o_any_pls || bus.lvl != prev_lvl)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_event: cycle %0d pls %0h lvl %0h any %0b, none expected",
                        cyc_cnt - base, bus.pls, bus.lvl, o_any_pls);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               chk("ev_cycle", cyc_cnt - base, e.cyc);
               chk("ev_pls",   bus.pls, e.pls);
               chk("ev_lvl",   bus.lvl, e.lvl);
               chk("ev_any",   o_any_pls, (e.pls != 5'b0));
            end
         end
         prev_lvl = bus.lvl;
      end
   end

   initial begin
      bus.raw = '0;
      rst     = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_lvl", o_lvl, 5'b0);
      chk("reset_pls", bus.pls, 5'b0);
      chk("reset_any", o_any_pls, 1'b0);
      @(posedge clk); #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      // C held 30 cycles: pulse and level rise at 6, level falls at 36.
      push(6,  5'b00001, 5'b00001);
      push(36, 5'b00000, 5'b00000);
      run(5'b00001, 30, -1, 45);
      do_reset();

      // E glitch of 3 cycles: filtered out entirely.
      run(5'b00010, 3, -1, 20);
      do_reset();

      // W held 40 cycles: press at 6, repeats 16,19..43, release at 46.
      push(6, 5'b00100, 5'b00100);
`ifdef AUTO_REPEAT_EN
      push(16, 5'b00100, 5'b00100);
      for (int c = 19; c <= 43; c += 3) push(c, 5'b00100, 5'b00100);
`endif
      push(46, 5'b00000, 5'b00000);
      run(5'b00100, 40, -1, 55);
      do_reset();

      // E held 12 cycles: released during the initial delay, one pulse only.
      push(6,  5'b00010, 5'b00010);
      push(18, 5'b00000, 5'b00000);
      run(5'b00010, 12, -1, 30);
      do_reset();

      // N and S together: simultaneous pulses, no repeats.
      push(6,  5'b11000, 5'b11000);
      push(16, 5'b00000, 5'b00000);
      run(5'b11000, 10, -1, 25);
      do_reset();

      // S held across a 1-cycle reset at cycle 20: re-accepted at 27.
      push(6,  5'b01000, 5'b01000);
      push(21, 5'b00000, 5'b00000);
      push(27, 5'b01000, 5'b01000);
      push(41, 5'b00000, 5'b00000);
      run(5'b01000, 35, 20, 50);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
